quad_decoder_counter: RTL and testbench

//  Quadrature (A/B Gray-code) decoder that turns encoder phase inputs into
//  up/down step events and holds them in a wrapping position counter.

---
 rtl/qdec_pkg.sv | 54 +++++
 rtl/qdec_sync.sv | 100 ++++++++++
 rtl/quad_decoder_counter.sv | 140 ++++++++++++++
 tb/tb_quad_decoder_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// ----------------------------------------------------------------------------
// qdec_pkg
// Shared definitions for the quadrature decoder/counter:
//   - Gray-code phase state constants ST_00/ST_01/ST_11/ST_10 ({A,B})
//   - direction constants DIR_UP/DIR_DN
//   - trans_t transition class (NONE/UP/DN/ILLEGAL) and classify()
// ----------------------------------------------------------------------------
package qdec_pkg;

   localparam logic [1:0] ST_00 = 2'b00;
   localparam logic [1:0] ST_01 = 2'b01;
   localparam logic [1:0] ST_11 = 2'b11;
   localparam logic [1:0] ST_10 = 2'b10;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   typedef enum logic [1:0] {
      TR_NONE    = 2'd0,
      TR_UP      = 2'd1,
      TR_DN      = 2'd2,
      TR_ILLEGAL = 2'd3
   } trans_t;

   // Next state when the encoder turns one step in the up direction.
   function automatic logic [1:0] gray_next_up(input logic [1:0] st);
      logic [1:0] nxt;
      case (st)
         ST_00:   nxt = ST_01;
         ST_01:   nxt = ST_11;
         ST_11:   nxt = ST_10;
         ST_10:   nxt = ST_00;
         default: nxt = ST_00;
      endcase
      return nxt;
   endfunction

   // Classify the move from prev to cur. Any change that is neither one step
   // forward nor one step back has flipped both phases at once.
   function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
      trans_t t;
      if (cur == prev) begin
         t = TR_NONE;
      end else if (cur == gray_next_up(prev)) begin
         t = TR_UP;
      end else if (prev == gray_next_up(cur)) begin
         t = TR_DN;
      end else begin
         t = TR_ILLEGAL;
      end
      return t;
   endfunction

endpackage

// File: rtl/qdec_sync.sv
// ----------------------------------------------------------------------------
// qdec_sync
// SYNC_STAGES-deep synchronizer for the 2-bit {A,B} bus with an optional
// glitch filter (compiled in with `QDEC_GLITCH_FILTER_EN).
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   ab_i     raw {A,B} pins, asynchronous to clk_i
//   s_o      synchronized (and, if enabled, filtered) phase state
//   valid_o  s_o carries a real sample taken since reset
// With the filter, a value is only passed on after the synchronized pair has
// held it for FILT_LEN consecutive cycles; shorter pulses are dropped.
// ----------------------------------------------------------------------------
module qdec_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] ab_i,
   output logic [1:0] s_o,
   output logic       valid_o
);

   if (SYNC_STAGES < 2 || FILT_LEN < 2) begin : g_bad_params
      $error("qdec_sync: SYNC_STAGES and FILT_LEN must both be at least 2");
   end

   logic [SYNC_STAGES-1:0][1:0] sync_q;
   // fill_q tracks how far real samples have propagated down the chain, so
   // the reset zeros in sync_q are never mistaken for an encoder state.
   logic [SYNC_STAGES-1:0]      fill_q;

   // Synchronizer chain and its fill tracker.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         fill_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ab_i};
         fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

`ifdef QDEC_GLITCH_FILTER_EN
   localparam int CNT_W = $clog2(FILT_LEN + 1);

   logic [1:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       filt_q, filt_d;
   logic             acc_q, acc_d;

   // Run-length filter: cnt_q counts cycles cand_q has been seen in a row.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      filt_d = filt_q;
      acc_d  = acc_q;
      if (!fill_q[SYNC_STAGES-1]) begin
         cand_d = 2'b00;
         cnt_d  = '0;
      end else if (sync_q[SYNC_STAGES-1] != cand_q) begin
         cand_d = sync_q[SYNC_STAGES-1];
         cnt_d  = CNT_W'(1);
      end else if (cnt_q < CNT_W'(FILT_LEN)) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
            filt_d = cand_q;
            acc_d  = 1'b1;
         end else begin
            acc_d = acc_q;
         end
      end else begin
         // Saturated: value already accepted, nothing to update.
         cnt_d = cnt_q;
      end
   end

   // Filter state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cand_q <= 2'b00;
         cnt_q  <= '0;
         filt_q <= 2'b00;
         acc_q  <= 1'b0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
         acc_q  <= acc_d;
      end
   end

   assign s_o     = filt_q;
   assign valid_o = acc_q;
`else
   assign s_o     = sync_q[SYNC_STAGES-1];
   assign valid_o = fill_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_decoder_counter.sv
// ----------------------------------------------------------------------------
// quad_decoder_counter
// Quadrature A/B decoder feeding a wrapping WIDTH-bit up/down position counter.
//   CLK       system clock, rising edge
//   RST       asynchronous active-low reset
//   A, B      encoder phases, asynchronous to CLK
//   P_C       parallel load (Q <= D), clears ERR_FLAG, wins over a step
//   D         parallel load value
//   Q         position count (modulo 2^WIDTH)
//   DIR       direction of last accepted step (1 = up)
//   STEP      one-cycle pulse per accepted step
//   ERR       one-cycle pulse when both phases changed in one cycle
//   ERR_FLAG  sticky error flag
// Optional glitch filter: define QDEC_GLITCH_FILTER_EN (see qdec_sync).
// Pin-to-output latency is SYNC_STAGES+1 cycles, plus FILT_LEN with the filter.
// ----------------------------------------------------------------------------
module quad_decoder_counter
   import qdec_pkg::*;
#(
   parameter int WIDTH       = 5,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             A,
   input  logic             B,
   input  logic             P_C,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             DIR,
   output logic             STEP,
   output logic             ERR,
   output logic             ERR_FLAG
);

   logic [1:0]       s_s;
   logic             s_valid_s;
   trans_t           trans_s;

   logic [WIDTH-1:0] q_q, q_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_q, err_d;
   logic             err_flag_q, err_flag_d;
   logic             primed_q, primed_d;
   logic [1:0]       prev_q, prev_d;

   qdec_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_sync (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .ab_i    ({A, B}),
      .s_o     (s_s),
      .valid_o (s_valid_s)
   );

   assign trans_s = classify(prev_q, s_s);

   // Priming, step classification, counter and flag next-state.
   always_comb begin
      q_d        = q_q;
      dir_d      = dir_q;
      step_d     = 1'b0;
      err_d      = 1'b0;
      err_flag_d = err_flag_q;
      primed_d   = primed_q;
      prev_d     = prev_q;
      if (!primed_q) begin
         // First valid state only seeds prev; it is not a step.
         if (s_valid_s) begin
            primed_d = 1'b1;
            prev_d   = s_s;
         end else begin
            primed_d = 1'b0;
         end
      end else begin
         prev_d = s_s;
         case (trans_s)
            TR_UP: begin
               q_d    = q_q + WIDTH'(1);
               dir_d  = DIR_UP;
               step_d = 1'b1;
            end
            TR_DN: begin
               q_d    = q_q - WIDTH'(1);
               dir_d  = DIR_DN;
               step_d = 1'b1;
            end
            TR_ILLEGAL: begin
               err_d      = 1'b1;
               err_flag_d = 1'b1;
            end
            default: begin
               step_d = 1'b0;
            end
         endcase
      end
      // Load overrides any step this cycle; ERR still pulses but the sticky
      // flag ends cleared. prev keeps tracking so no phantom step follows.
      if (P_C) begin
         q_d        = D;
         step_d     = 1'b0;
         dir_d      = dir_q;
         err_flag_d = 1'b0;
      end else begin
         err_flag_d = err_flag_d;
      end
   end

   // Output and decoder state registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         q_q        <= '0;
         dir_q      <= 1'b0;
         step_q     <= 1'b0;
         err_q      <= 1'b0;
         err_flag_q <= 1'b0;
         primed_q   <= 1'b0;
         prev_q     <= ST_00;
      end else begin
         q_q        <= q_d;
         dir_q      <= dir_d;
         step_q     <= step_d;
         err_q      <= err_d;
         err_flag_q <= err_flag_d;
         primed_q   <= primed_d;
         prev_q     <= prev_d;
      end
   end

   assign Q        = q_q;
   assign DIR      = dir_q;
   assign STEP     = step_q;
   assign ERR      = err_q;
   assign ERR_FLAG = err_flag_q;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// ----------------------------------------------------------------------------
// tb_quad_decoder_counter
// Directed bench for quad_decoder_counter (WIDTH=5, SYNC_STAGES=2, FILT_LEN=4).
// A position model checks every output on every clock; directed scenarios
// add literal expectations on top.
// ----------------------------------------------------------------------------
module tb_quad_decoder_counter;

   localparam int W  = 5;
   localparam int SS = 2;
   localparam int FL = 4;
`ifdef QDEC_GLITCH_FILTER_EN
   localparam int LAT = SS + FL + 1;
`else
   localparam int LAT = SS + 1;
`endif

   logic         CLK = 1'b0;
   logic         RST, A, B, P_C;
   logic [W-1:0] D;
   logic [W-1:0] Q;
   logic         DIR, STEP, ERR, ERR_FLAG;

   int n_tests = 0;
   int n_fail  = 0;
   int dut_steps = 0;
   int dut_errs  = 0;

   quad_decoder_counter #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_LEN(FL)) dut (
      .CLK(CLK), .RST(RST), .A(A), .B(B), .P_C(P_C), .D(D),
      .Q(Q), .DIR(DIR), .STEP(STEP), .ERR(ERR), .ERR_FLAG(ERR_FLAG)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Phase index of a Gray state around the circle 00,01,11,10.
   function automatic int phase_idx(input logic [1:0] g);
      return {30'd0, g[1], g[1] ^ g[0]};
   endfunction

   // ---------------- behavioural model ----------------
   int         m_q, m_dir, m_step, m_err, m_flag, m_primed;
   logic [1:0] m_prev;
   logic [1:0] hist[$];
   int         run_len;
   logic [1:0] run_val, acc_val;
   int         acc_valid;

   initial begin
      logic [1:0] pins, s_val, use_val;
      int         s_ok, use_ok, diff, new_q, new_dir;
      forever begin
         @(posedge CLK);
         if (!RST) begin
            m_q = 0; m_dir = 0; m_step = 0; m_err = 0; m_flag = 0;
            m_primed = 0; m_prev = 2'b00; hist.delete();
            run_len = 0; run_val = 2'b00; acc_val = 2'b00; acc_valid = 0;
         end else begin
            pins  = {A, B};
            s_ok  = (hist.size() >= SS) ? 1 : 0;
            s_val = (s_ok != 0) ? hist[SS-1] : 2'b00;
`ifdef QDEC_GLITCH_FILTER_EN
            use_ok  = acc_valid;
            use_val = acc_val;
            if (s_ok == 0) begin
               run_val = 2'b00; run_len = 0;
            end else if (s_val == run_val) begin
               run_len++;
            end else begin
               run_val = s_val; run_len = 1;
            end
            if (run_len == FL) begin
               acc_val = run_val; acc_valid = 1;
            end
`else
            use_ok  = s_ok;
            use_val = s_val;
`endif
            hist.push_front(pins);
            if (hist.size() > SS) void'(hist.pop_back());

            m_step = 0; m_err = 0;
            new_q = m_q; new_dir = m_dir;
            if (m_primed == 0) begin
               if (use_ok != 0) begin
                  m_primed = 1; m_prev = use_val;
               end
            end else begin
               diff = (phase_idx(use_val) - phase_idx(m_prev) + 4) % 4;
               if (diff == 1) begin
                  new_q = (m_q + 1) % (1 << W); new_dir = 1; m_step = 1;
               end else if (diff == 3) begin
                  new_q = (m_q + (1 << W) - 1) % (1 << W); new_dir = 0; m_step = 1;
               end else if (diff == 2) begin
                  m_err = 1; m_flag = 1;
               end
               m_prev = use_val;
            end
            if (P_C) begin
               new_q = int'(D); new_dir = m_dir; m_step = 0; m_flag = 0;
            end
            m_q = new_q; m_dir = new_dir;
         end
         #1;
         chk("model_Q", int'(Q), m_q);
         chk("model_DIR", int'(DIR), m_dir);
         chk("model_STEP", int'(STEP), m_step);
         chk("model_ERR", int'(ERR), m_err);
         chk("model_ERR_FLAG", int'(ERR_FLAG), m_flag);
         if (STEP) dut_steps++;
         if (ERR) dut_errs++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic set_ab(input logic [1:0] v, input int hold);
      A = v[1]; B = v[0];
      cyc(hold);
   endtask

   task automatic pc_load(input logic [W-1:0] v);
      P_C = 1'b1; D = v;
      @(negedge CLK);
      P_C = 1'b0;
      cyc(2);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int s0, e0;
      RST = 1'b0; A = 1'b0; B = 1'b0; P_C = 1'b0; D = '0;
      #3;
      chk("reset_Q", int'(Q), 0);
      chk("reset_STEP", int'(STEP), 0);
      chk("reset_ERR_FLAG", int'(ERR_FLAG), 0);
      cyc(2);
      RST = 1'b1;
      cyc(10);

      // 1: bring Q to 7 counting up, then async reset mid-cycle
      pc_load(5'd5);
      set_ab(2'b01, 8);
      set_ab(2'b11, 8);
      chk("t1_pre_Q", int'(Q), 7);
      chk("t1_pre_DIR", int'(DIR), 1);
      #2 RST = 1'b0;
      #1;
      chk("t1_rst_Q", int'(Q), 0);
      chk("t1_rst_DIR", int'(DIR), 0);
      chk("t1_rst_STEP", int'(STEP), 0);
      chk("t1_rst_ERR_FLAG", int'(ERR_FLAG), 0);
      A = 1'b0; B = 1'b0;
      cyc(2);
      RST = 1'b1;
      cyc(10);
      chk("t1_reprime_Q", int'(Q), 0);

      // 2: two full up cycles, first edge checked for latency
      s0 = dut_steps;
      A = 1'b0; B = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         @(posedge CLK);
         #1;
         chk("t2_step_latency", int'(STEP), (k == LAT) ? 1 : 0);
      end
      cyc(8);
      set_ab(2'b11, 8); set_ab(2'b10, 8); set_ab(2'b00, 8);
      set_ab(2'b01, 8); set_ab(2'b11, 8); set_ab(2'b10, 8); set_ab(2'b00, 8);
      chk("t2_steps", dut_steps - s0, 8);
      chk("t2_Q", int'(Q), 8);
      chk("t2_DIR", int'(DIR), 1);

      // 3: wrap up from 31 and down from 0
      pc_load(5'd31);
      chk("t3_load_Q", int'(Q), 31);
      set_ab(2'b01, 8);
      chk("t3_up_wrap_Q", int'(Q), 0);
      set_ab(2'b00, 8);
      chk("t3_dn_wrap_Q", int'(Q), 31);
      chk("t3_dn_DIR", int'(DIR), 0);

      // 4: illegal transition, then clear with load
      s0 = dut_steps; e0 = dut_errs;
      set_ab(2'b11, 8);
      chk("t4_err_pulses", dut_errs - e0, 1);
      chk("t4_ERR_FLAG", int'(ERR_FLAG), 1);
      chk("t4_Q", int'(Q), 31);
      chk("t4_steps", dut_steps - s0, 0);
      pc_load(5'd10);
      chk("t4_clr_ERR_FLAG", int'(ERR_FLAG), 0);
      chk("t4_clr_Q", int'(Q), 10);

      // 5: load coincides with classification of an up step
      s0 = dut_steps;
      A = 1'b1; B = 1'b0;
      cyc(LAT - 1);
      P_C = 1'b1; D = 5'd10;
      @(negedge CLK);
      P_C = 1'b0;
      cyc(8);
      chk("t5_Q", int'(Q), 10);
      chk("t5_steps", dut_steps - s0, 0);
      chk("t5_DIR_held", int'(DIR), 0);
      set_ab(2'b00, 8);
      chk("t5_next_up_Q", int'(Q), 11);
      chk("t5_next_DIR", int'(DIR), 1);

      // 6: 2-cycle pulse on A
      s0 = dut_steps;
      set_ab(2'b10, 2);
      set_ab(2'b00, 12);
      chk("t6_Q", int'(Q), 11);
`ifdef QDEC_GLITCH_FILTER_EN
      chk("t6_steps", dut_steps - s0, 0);
`else
      chk("t6_steps", dut_steps - s0, 2);
      chk("t6_DIR", int'(DIR), 1);
`endif

      cyc(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
